// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: sequencer state encoding and lock-loss counter width.
package clk_rst_pkg;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABILIZE = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } seq_state_e;

  // $clog2 of a parameter, but never below 1 bit so a ratio of 1 still gets a real counter.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a synchronous clear.
module sync_2ff (
  input  logic clk,
  input  logic i_clear,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds downstream logic in reset until the PLL lock has been stable, then releases it
// and generates a divided clock-enable; any loss of lock drops straight back into reset.
module pll_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CE_DIV        = 4
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  pll_locked,
  output logic                  sys_reset,
  output logic                  sys_ready,
  output logic                  ce,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output seq_state_e            o_dbg_state
);

  localparam int STAB_W = clog2_min1(STABLE_CYCLES);
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);
  localparam int CE_W   = clog2_min1(CE_DIV);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_DIV - 1);

  logic        w_lk;
  seq_state_e  r_state;
  seq_state_e  w_next_state;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CE_W-1:0]   r_ce_cnt;

  sync_2ff u_lock_sync (
    .clk     (clock_in),
    .i_clear (reset),
    .i_d     (pll_locked),
    .o_q     (w_lk)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_LOCK: if (w_lk) w_next_state = ST_STABILIZE;
      ST_STABILIZE: begin
        if (!w_lk)                      w_next_state = ST_WAIT_LOCK;
        else if (r_stab_cnt == STAB_LAST) w_next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (!w_lk)                      w_next_state = ST_WAIT_LOCK;
        else if (r_hold_cnt == HOLD_LAST) w_next_state = ST_RUN;
      end
      ST_RUN:  if (!w_lk) w_next_state = ST_LOST;
      ST_LOST: w_next_state = ST_WAIT_LOCK;
      default: w_next_state = ST_WAIT_LOCK;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state         <= ST_WAIT_LOCK;
      r_stab_cnt      <= '0;
      r_hold_cnt      <= '0;
      r_ce_cnt        <= '0;
      sys_reset       <= 1'b1;
      sys_ready       <= 1'b0;
      ce              <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      r_state   <= w_next_state;
      sys_reset <= (w_next_state != ST_RUN);
      sys_ready <= (w_next_state == ST_RUN);

      if (r_state == ST_STABILIZE && w_next_state == ST_STABILIZE) r_stab_cnt <= r_stab_cnt + 1'b1;
      else                                                          r_stab_cnt <= '0;

      if (r_state == ST_HOLD && w_next_state == ST_HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
      else                                                r_hold_cnt <= '0;

      if (r_state == ST_RUN) r_ce_cnt <= (r_ce_cnt == CE_LAST) ? '0 : r_ce_cnt + 1'b1;
      else                   r_ce_cnt <= '0;

      ce <= (r_state == ST_RUN) && (w_next_state == ST_RUN) && (r_ce_cnt == CE_LAST);

      if (r_state == ST_RUN && w_next_state == ST_LOST && lock_loss_count != '1)
        lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with STABLE_CYCLES=8, HOLD_CYCLES=4, CE_DIV=4.
module tb_pll_reset_sequencer;
  import clk_rst_pkg::*;

  logic                  clock_in = 1'b0;
  logic                  reset = 1'b1;
  logic                  pll_locked = 1'b0;
  logic                  sys_reset;
  logic                  sys_ready;
  logic                  ce;
  logic [LOSS_CNT_W-1:0] lock_loss_count;
  seq_state_e            o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Release takes 2 sync + 1 WAIT_LOCK exit + 8 STABILIZE + 4 HOLD edges after lock is seen.
  localparam int RELEASE_EDGES = 15;

  pll_reset_sequencer #(
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4),
    .CE_DIV        (4)
  ) dut (
    .clock_in        (clock_in),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .sys_reset       (sys_reset),
    .sys_ready       (sys_ready),
    .ce              (ce),
    .lock_loss_count (lock_loss_count),
    .o_dbg_state     (o_dbg_state)
  );

  always #5 clock_in = ~clock_in;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  // Count edges until sys_reset falls; returns limit+1 if it never does.
  task automatic wait_release(input int limit, output int n);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (sys_reset === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sys_reset got=%b exp=1", sys_reset); end
    n_checks++; if (sys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sys_ready got=%b exp=0", sys_ready); end
    n_checks++; if (ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got=%b exp=0", ce); end
    n_checks++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_loss_count got=%0d exp=0", lock_loss_count); end
    n_checks++; if (o_dbg_state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, ST_WAIT_LOCK); end
    pll_locked = 1'b1;
    repeat (4) tick();
    n_checks++; if (sys_reset !== 1'b1 || o_dbg_state !== ST_WAIT_LOCK) begin
      n_fail++; $display("FAIL reset_priority got sys_reset=%b state=%0d exp 1/%0d", sys_reset, o_dbg_state, ST_WAIT_LOCK);
    end
  endtask

  task automatic test_release();
    int n;
    reset = 1'b1;
    pll_locked = 1'b1;
    tick();
    reset = 1'b0;
    wait_release(60, n);
    n_checks++; if (n != RELEASE_EDGES) begin n_fail++; $display("FAIL release_cycles got=%0d exp=%0d", n, RELEASE_EDGES); end
    n_checks++; if (sys_ready !== 1'b1 || o_dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL release_ready got ready=%b state=%0d exp 1/%0d", sys_ready, o_dbg_state, ST_RUN);
    end
  endtask

  // Called on the edge RUN is entered; pulses expected 4,8,12,16,20 edges later.
  task automatic test_ce();
    logic [7:0] exp_q[$];
    logic [7:0] exp_pos;
    int pulses = 0;
    int bad = 0;
    for (int k = 1; k <= 5; k++) exp_q.push_back(8'(4 * k));
    n_checks++; if (ce !== 1'b0) begin n_fail++; $display("FAIL ce_at_entry got=%b exp=0", ce); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ce === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL ce_position got=%0d exp=none", i);
        end else begin
          exp_pos = exp_q.pop_front();
          if (8'(i) !== exp_pos) begin bad++; $display("FAIL ce_position got=%0d exp=%0d", i, exp_pos); end
        end
      end
    end
    n_checks++; if (bad != 0) n_fail++;
    n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL ce_pulse_count got=%0d exp=5", pulses); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ce_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_lock_loss();
    n_checks++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL loss_before got=%0d exp=0", lock_loss_count); end
    pll_locked = 1'b0;
    tick();
    tick();
    n_checks++; if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL loss_early got=%b exp=0", sys_reset); end
    tick();
    n_checks++; if (sys_reset !== 1'b1 || sys_ready !== 1'b0) begin
      n_fail++; $display("FAIL loss_sys_reset got reset=%b ready=%b exp 1/0", sys_reset, sys_ready);
    end
    n_checks++; if (o_dbg_state !== ST_LOST) begin n_fail++; $display("FAIL loss_state got=%0d exp=%0d", o_dbg_state, ST_LOST); end
    n_checks++; if (lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL loss_count got=%0d exp=1", lock_loss_count); end
    tick();
    n_checks++; if (o_dbg_state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL loss_to_wait got=%0d exp=%0d", o_dbg_state, ST_WAIT_LOCK); end
    begin
      int ce_seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (ce === 1'b1) ce_seen++;
        tick();
      end
      n_checks++; if (ce_seen != 0) begin n_fail++; $display("FAIL loss_ce_stopped got=%0d exp=0", ce_seen); end
    end
  endtask

  task automatic test_reset_in_run();
    int n;
    pll_locked = 1'b1;
    wait_release(60, n);
    n_checks++; if (n != RELEASE_EDGES) begin n_fail++; $display("FAIL relock_cycles got=%0d exp=%0d", n, RELEASE_EDGES); end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (sys_reset !== 1'b1 || sys_ready !== 1'b0 || ce !== 1'b0) begin
      n_fail++; $display("FAIL run_reset_outputs got reset=%b ready=%b ce=%b exp 1/0/0", sys_reset, sys_ready, ce);
    end
    n_checks++; if (o_dbg_state !== ST_WAIT_LOCK) begin n_fail++; $display("FAIL run_reset_state got=%0d exp=%0d", o_dbg_state, ST_WAIT_LOCK); end
    n_checks++; if (lock_loss_count !== 8'd0) begin n_fail++; $display("FAIL run_reset_count got=%0d exp=0", lock_loss_count); end
    wait_release(60, n);
    n_checks++; if (n != RELEASE_EDGES) begin n_fail++; $display("FAIL run_reset_rerelease got=%0d exp=%0d", n, RELEASE_EDGES); end
  endtask

  task automatic test_stabilize_glitch();
    int n;
    reset = 1'b1;
    pll_locked = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    n_checks++; if (o_dbg_state !== ST_STABILIZE) begin n_fail++; $display("FAIL glitch_pre_state got=%0d exp=%0d", o_dbg_state, ST_STABILIZE); end
    pll_locked = 1'b0;
    repeat (3) tick();
    n_checks++; if (o_dbg_state !== ST_WAIT_LOCK || sys_reset !== 1'b1) begin
      n_fail++; $display("FAIL glitch_restart got state=%0d reset=%b exp %0d/1", o_dbg_state, sys_reset, ST_WAIT_LOCK);
    end
    pll_locked = 1'b1;
    wait_release(60, n);
    n_checks++; if (n != RELEASE_EDGES) begin n_fail++; $display("FAIL glitch_release got=%0d exp=%0d", n, RELEASE_EDGES); end
  endtask

  task automatic test_loss_saturation();
    int n;
    int slow = 0;
    for (int k = 1; k <= 300; k++) begin
      pll_locked = 1'b0;
      repeat (4) tick();
      if (k == 1) begin
        n_checks++; if (lock_loss_count !== 8'd1) begin n_fail++; $display("FAIL sat_first got=%0d exp=1", lock_loss_count); end
      end
      if (k == 255 || k == 256) begin
        n_checks++; if (lock_loss_count !== 8'd255) begin n_fail++; $display("FAIL sat_at_%0d got=%0d exp=255", k, lock_loss_count); end
      end
      pll_locked = 1'b1;
      wait_release(40, n);
      if (n != RELEASE_EDGES) slow++;
    end
    n_checks++; if (slow != 0) begin n_fail++; $display("FAIL sat_release_timing got=%0d exp=0", slow); end
    n_checks++; if (lock_loss_count !== 8'd255) begin n_fail++; $display("FAIL sat_final got=%0d exp=255", lock_loss_count); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_ce();
    test_lock_loss();
    test_reset_in_run();
    test_stabilize_glitch();
    test_loss_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive cycles `pll_locked` must be high before release begins (range 2..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles `sys_reset` stays asserted after stabilisation (range 1..255).
REQ-003 SHALL have parameter CE_DIV, default 4: divide ratio of the clock-enable pulse (range 2..256).
REQ-004 SHALL have port `clock_in`, input, 1 bit: the single clock, the PLL output clock domain.
REQ-005 SHALL have port `reset`, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port `pll_locked`, input, 1 bit: PLL LOCK output, asynchronous to `clock_in`.
REQ-007 SHALL have port `sys_reset`, output, 1 bit: synchronous active-high reset for downstream logic.
REQ-008 SHALL have port `sys_ready`, output, 1 bit: high only in state RUN.
REQ-009 SHALL have port `ce`, output, 1 bit: one-cycle clock-enable pulse, every CE_DIV cycles, only in RUN.
REQ-010 SHALL have port `lock_loss_count`, output, 8 bits: number of RUN-to-LOST transitions, saturating at 255.

Function
REQ-011 SHALL pass `pll_locked` through a 2-flop synchroniser; all logic uses the synchronised value `lk` (2-cycle input latency).
REQ-012 SHALL implement FSM states WAIT_LOCK, STABILIZE, HOLD, RUN and LOST.
REQ-013 WAIT_LOCK: when `lk`=1, clear the stability counter and go to STABILIZE.
REQ-014 STABILIZE: increment the counter each cycle `lk`=1; `lk`=0 returns to WAIT_LOCK with the counter cleared; on reaching STABLE_CYCLES-1, clear the counter and go to HOLD.
REQ-015 HOLD: count HOLD_CYCLES cycles, then go to RUN; `lk`=0 during HOLD goes to WAIT_LOCK.
REQ-016 RUN: `lk`=0 goes to LOST the next cycle and increments `lock_loss_count` (saturating at 255).
REQ-017 LOST: unconditionally go to WAIT_LOCK the next cycle.
REQ-018 `sys_reset` SHALL be registered, equal 1 in every state except RUN, and deassert in the same cycle the FSM enters RUN.
REQ-019 `sys_reset` SHALL reassert in the cycle the FSM enters LOST, i.e. 3 cycles after the `pll_locked` falling edge (2 synchroniser cycles + 1).
REQ-020 `sys_ready` SHALL be registered and equal the inverse of `sys_reset`.
REQ-021 The CE divider counter SHALL be held at 0 outside RUN; in RUN it counts 0..CE_DIV-1 and wraps.
REQ-022 `ce` SHALL pulse when the divider counter equals CE_DIV-1; the first pulse occurs CE_DIV cycles after `sys_ready` rises.
REQ-023 A `pll_locked` glitch shorter than 2 cycles MAY be missed by the synchroniser; any glitch that is captured SHALL restart stabilisation.
REQ-024 Counter widths SHALL be $clog2 of their parameter; arithmetic SHALL be unsigned with no overflow inside the parameter ranges.

Reset
REQ-025 `reset`=1 SHALL synchronously force: state WAIT_LOCK, all counters 0, synchroniser flops 0, `sys_reset`=1, `sys_ready`=0, `ce`=0, `lock_loss_count`=0.
REQ-026 `reset` SHALL take priority over every FSM transition, including when asserted mid-RUN or mid-STABILIZE.
REQ-027 `sys_reset` SHALL never be 0 in the cycle following a cycle with `reset`=1.

Structure
REQ-028 The state encoding (5 states, 3-bit enum) and the LOSS_CNT_W=8 constant SHALL live in the shared package `clk_rst_pkg`.
REQ-029 The 2-flop synchroniser SHALL be the sub-module `sync_2ff` (1-bit, no reset on data path except the synchronous clear).
REQ-030 The block SHALL instantiate no PLL primitive; it consumes the PLL wrapper's `locked` output.

Verification
REQ-031 Hold `pll_locked`=1 from reset release, STABLE_CYCLES=8, HOLD_CYCLES=4 -> `sys_reset` falls at cycle 2+8+4 (±1 per FSM entry cycle), and the count SHALL be checked exactly.
REQ-032 Drop `pll_locked` for 3 cycles in mid-STABILIZE at cycle 5 -> FSM returns to WAIT_LOCK, and release occurs STABLE_CYCLES+HOLD_CYCLES after `lk` rises again.
REQ-033 In RUN, drop `pll_locked` -> `sys_reset`=1 exactly 3 cycles later, `lock_loss_count` increments 0->1, and `ce` stops.
REQ-034 CE_DIV=4 in RUN for 20 cycles -> exactly 5 `ce` pulses, each 1 cycle wide, 4 cycles apart.
REQ-035 Force 300 lock losses -> `lock_loss_count` reads 255, with no wrap.
REQ-036 Assert `reset` for 1 cycle in RUN -> the next cycle has `sys_reset`=1, state WAIT_LOCK and counters 0, and re-release takes the full sequence.
